coef_bank_ram: RTL and testbench
================================

# coef_bank_ram

Double-buffered, parametrised coefficient store for the DDS datapath, succeeding the fixed 48-bit coefficient PROM. It provides two banks of `2**ADDR_W` words, each `DATA_W` bits wide. Software loads the shadow bank while the active bank is being read, then swaps banks at a frame-safe point. Reads use the familiar two-stage `ce`/`oce` pipeline, addressed either directly or by an internal auto-sweep pointer that wraps at a programmable last address.

## Interface
Parameters:
- `DATA_W`, 48, coefficient word width.
- `ADDR_W`, 4, address width; each bank holds `2**ADDR_W` words.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  stage-1 read enable; also advances the sweep pointer.
- `oce`  in  1  stage-2 output-register enable.
- `mode`  in  1  read addressing: 0 = direct (`ad`), 1 = auto-sweep.
- `ad`  in  ADDR_W  direct read address, used when `mode`=0.
- `sweep_last`  in  ADDR_W  last sweep address; the pointer wraps to 0 after it.
- `wr_en`  in  1  write strobe; always targets the shadow bank.
- `wr_ad`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `swap_req`  in  1  single-cycle request to exchange active and shadow banks.
- `swap_done`  out  1  one-cycle pulse on the edge where the swap takes effect.
- `active_bank`  out  1  bank currently read.
- `sweep_ad`  out  ADDR_W  current sweep pointer.
- `dout`  out  DATA_W  coefficient output.
- `dout_valid`  out  1  `dout` holds a word read since reset.

## Operation
- **Storage**
  - Memory is `2**(ADDR_W+1)` words, indexed by `{bank, addr}`.
  - Write at an edge with `wr_en`=1: `mem[{~active_bank, wr_ad}] <= wr_data`.
  - Reads always use `{active_bank, rd_ad}`.
  - `rd_ad` = `ad` when `mode`=0, `sweep_ad` when `mode`=1.
- **Stage 1** (edge with `ce`=1): `q1 <= mem[{active_bank, rd_ad}]` and `v1 <= 1`. With `ce`=0, `q1` and `v1` hold.
- **Stage 2** (edge with `oce`=1): `dout <= q1` and `dout_valid <= v1`. With `oce`=0, both hold.
- **Sweep pointer**
  - `mode`=0: forced to 0 every edge.
  - `mode`=1, `ce`=1: if `sweep_ad`==`sweep_last`, next value is 0; otherwise `sweep_ad`+1.
  - `mode`=1, `ce`=0: holds.
  - `sweep_last`=0 reads address 0 repeatedly.
- **Swap state machine** (IDLE, PEND)
  - IDLE → PEND on `swap_req`=1, unless the swap fires on that same edge.
  - Safe point:
    - `mode`=0: always.
    - `mode`=1: `ce`=1 and `sweep_ad`==`sweep_last`.
  - Fire condition: (PEND or `swap_req`) and safe point.
  - On fire: `active_bank` toggles, `swap_done` = 1 for one cycle, state returns to IDLE.
  - `swap_req` while in PEND is ignored; there is never a double toggle.
- **Same-edge events**
  - The read on the firing edge uses the old bank.
  - A write on the firing edge lands in the old shadow bank, which becomes active; data is readable from the next edge.
  - A write never collides with the active bank.
- **Reset**
  - Memory contents are not cleared.
  - Asserting `reset` mid-operation discards any pending swap, clears the pipeline, and returns `active_bank` to 0.

## Timing
- Reset values:
  - `dout` = 0
  - `dout_valid` = 0
  - `active_bank` = 0
  - `sweep_ad` = 0
  - `swap_done` = 0
  - swap FSM = IDLE
  - `q1` = 0, `v1` = 0
- Read latency with `ce`=`oce`=1: address presented in cycle N appears on `dout` after the edge ending cycle N+1 (two edges).
- Swap latency:
  - `mode`=0: `swap_req` in cycle N gives `swap_done` and the new `active_bank` after the edge ending cycle N. A read issued in cycle N+1 uses the new bank.
  - `mode`=1: the swap fires on the edge that reads address `sweep_last`, so every sweep frame comes entirely from one bank.
- Throughput: one word per cycle; no bubbles at wrap or swap.

## Structure
- Package `coef_pkg`:
  - `COEF_DATA_W` = 48, `COEF_ADDR_W` = 4.
  - Swap-state typedef (IDLE, PEND).
- Sub-module `coef_sdpram`:
  - Simple dual-port RAM: one write port, one read port with `ce`-gated registered output.
  - Address width `ADDR_W`+1.
  - Inferable as block RAM.
- Top level holds the sweep pointer, swap FSM, bank select and the `oce` output register.

## Test plan
All scenarios use `DATA_W`=48, `ADDR_W`=4.
1. Release `reset` after 10 cycles → `dout`=0, `dout_valid`=0, `active_bank`=0, `sweep_ad`=0.
2. Write words 1, 2, 3, 4 to shadow addresses 0–3; pulse `swap_req` with `mode`=0 → `swap_done` for one cycle and `active_bank`=1. Then `ad`=2 with `ce`=`oce`=1 → `dout`=48'h3 with `dout_valid`=1 two edges later.
3. `ce`=1, `oce`=0 while stepping `ad` 0→3 → `dout` frozen. Raise `oce` → `dout`=48'h4 (last stage-1 word).
4. `mode`=1, `sweep_last`=3, `ce`=`oce`=1 → `dout` sequence 1, 2, 3, 4, 1, 2, … after 2-cycle latency; `sweep_ad` wraps 3→0.
5. During scenario 4:
   - Load shadow bank 0 with 48'h10–48'h13.
   - Pulse `swap_req` while `sweep_ad`=1.
   - Expected: `swap_done` on the edge reading address 3; output continues …, 3, 4, 48'h10, 48'h11, 48'h12, 48'h13 with no mixed frame. A second `swap_req` issued while pending is ignored.
6. Assert `reset` mid-sweep with a swap pending → all outputs return to reset values, no `swap_done` follows, and memory contents are preserved (a read of bank 0 after reset returns 48'h10 at address 0).

Source files
------------

// File: rtl/coef_pkg.sv
// Shared widths and the bank-swap state encoding for the coefficient store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coef_pkg;

  localparam int COEF_DATA_W = 48;
  localparam int COEF_ADDR_W = 4;

  // IDLE: no swap outstanding; PEND: swap requested, waiting for a safe point.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } swap_state_t;

endpackage

// File: rtl/coef_sdpram.sv
// Simple dual-port RAM: one write port, one read port with ce-gated registered output.
// Latency: one edge from read address to o_q (when i_rd_ce=1).
// Backpressure: none; i_rd_ce=0 holds o_q.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset (clears o_q only)
//   i_wr_en/ad/data     write port
//   i_rd_ce, i_rd_ad    read enable and address
//   o_q                 registered read data
module coef_sdpram #(
  parameter int DATA_W = 48,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_ad,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_ce,
  input  logic [AW-1:0]     i_rd_ad,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_q;

  // Storage has no reset so it maps onto block RAM and survives a reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_ad] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_q <= '0;
    else if (i_rd_ce) r_q <= r_mem[i_rd_ad];
  end

  assign o_q = r_q;

endmodule

// File: rtl/coef_bank_ram.sv
// Double-buffered coefficient store: shadow bank loads while active bank is read; swaps at frame-safe points.
// Latency: two edges from read address (ad or sweep pointer) to dout with ce=oce=1.
// Backpressure: none; ce/oce gate each pipeline stage and hold it when low.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ce, oce                    stage-1 read enable (also steps sweep), stage-2 output enable
//   mode, ad, sweep_last       0: direct address ad; 1: auto-sweep 0..sweep_last
//   wr_en, wr_ad, wr_data      write into the shadow bank
//   swap_req, swap_done        swap request pulse, one-cycle swap-taken pulse
//   active_bank, sweep_ad      bank being read, current sweep pointer
//   dout, dout_valid           coefficient output and its valid flag
module coef_bank_ram
  import coef_pkg::*;
#(
  parameter int DATA_W = COEF_DATA_W,
  parameter int ADDR_W = COEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              mode,
  input  logic [ADDR_W-1:0] ad,
  input  logic [ADDR_W-1:0] sweep_last,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_ad,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              active_bank,
  output logic [ADDR_W-1:0] sweep_ad,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  swap_state_t       r_state, w_state_nxt;
  logic              r_active_bank;
  logic              r_swap_done;
  logic [ADDR_W-1:0] r_sweep_ad;
  logic              r_v1;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic [ADDR_W-1:0] w_rd_ad;
  logic              w_at_last;
  logic              w_safe;
  logic              w_fire;
  logic [DATA_W-1:0] w_q1;

  assign w_rd_ad   = mode ? r_sweep_ad : ad;
  assign w_at_last = (r_sweep_ad == sweep_last);
  // In sweep mode the only safe point is the edge that reads the last word of
  // the frame, so the next frame starts cleanly from the other bank.
  assign w_safe    = !mode || (ce && w_at_last);
  assign w_fire    = ((r_state == ST_PEND) || swap_req) && w_safe;

  // Write targets the shadow bank as seen before this edge; on a firing edge
  // that is the bank about to become active.
  coef_sdpram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (wr_en),
    .i_wr_ad   ({~r_active_bank, wr_ad}),
    .i_wr_data (wr_data),
    .i_rd_ce   (ce),
    .i_rd_ad   ({r_active_bank, w_rd_ad}),
    .o_q       (w_q1)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (swap_req && !w_fire) w_state_nxt = ST_PEND;
      ST_PEND: if (w_fire)              w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_active_bank <= 1'b0;
      r_swap_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_swap_done <= w_fire;
      if (w_fire) r_active_bank <= ~r_active_bank;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sweep_ad <= '0;
    end else if (!mode) begin
      r_sweep_ad <= '0;
    end else if (ce) begin
      r_sweep_ad <= w_at_last ? '0 : r_sweep_ad + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1         <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (ce) r_v1 <= 1'b1;
      if (oce) begin
        r_dout       <= w_q1;
        r_dout_valid <= r_v1;
      end
    end
  end

  assign swap_done   = r_swap_done;
  assign active_bank = r_active_bank;
  assign sweep_ad    = r_sweep_ad;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;

endmodule

// File: tb/tb_coef_bank_ram.sv
module tb_coef_bank_ram;

  localparam int DW = 48;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce, oce, mode;
  logic [AW-1:0] ad, sweep_last, wr_ad;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic          swap_done;
  logic          active_bank;
  logic [AW-1:0] sweep_ad;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  coef_bank_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .oce         (oce),
    .mode        (mode),
    .ad          (ad),
    .sweep_last  (sweep_last),
    .wr_en       (wr_en),
    .wr_ad       (wr_ad),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .active_bank (active_bank),
    .sweep_ad    (sweep_ad),
    .dout        (dout),
    .dout_valid  (dout_valid)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dout"},   dout,               '0);
    check({tag, "_valid"},  {47'd0, dout_valid}, '0);
    check({tag, "_bank"},   {47'd0, active_bank}, '0);
    check({tag, "_sweep"},  {44'd0, sweep_ad},   '0);
    check({tag, "_sdone"},  {47'd0, swap_done},  '0);
  endtask

  logic [DW-1:0] exp5 [10];

  initial begin
    reset = 1'b1; ce = 0; oce = 0; mode = 0; ad = '0; sweep_last = '0;
    wr_en = 0; wr_ad = '0; wr_data = '0; swap_req = 0;

    // 1: reset values
    repeat (10) step();
    check_reset_vals("rst");
    reset = 1'b0;

    // 2: load shadow bank 1, swap in direct mode, read ad=2
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_ad = AW'(i); wr_data = DW'(i + 1);
      step();
    end
    wr_en = 0;
    check("bank_before_swap", {47'd0, active_bank}, 48'd0);
    swap_req = 1;
    step();
    swap_req = 0;
    check("swap_done_dir", {47'd0, swap_done}, 48'd1);
    check("bank_after_swap", {47'd0, active_bank}, 48'd1);
    step();
    check("swap_done_pulse", {47'd0, swap_done}, 48'd0);
    check("bank_stays", {47'd0, active_bank}, 48'd1);
    ad = 4'd2; ce = 1; oce = 1;
    step();
    check("valid_lat1", {47'd0, dout_valid}, 48'd0);
    step();
    check("dout_ad2", dout, 48'h3);
    check("valid_ad2", {47'd0, dout_valid}, 48'd1);

    // 3: oce=0 freezes dout while stage 1 keeps reading
    oce = 0;
    for (int i = 0; i < 4; i++) begin
      ad = AW'(i);
      step();
      check("dout_frozen", dout, 48'h3);
    end
    ce = 0; oce = 1;
    step();
    check("dout_oce_release", dout, 48'h4);

    // 4: auto sweep 0..3 from bank 1
    mode = 1; sweep_last = 4'd3; ce = 1; oce = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("sweep_ptr", {44'd0, sweep_ad}, DW'(k % 4));
      check("sweep_dout", dout, (k >= 2) ? DW'(((k - 2) % 4) + 1) : 48'h4);
    end

    // 5: load bank 0 during sweep, request swap at sweep_ad=1, repeat request while pending
    exp5 = '{48'h4, 48'h1, 48'h2, 48'h3, 48'h4, 48'h10, 48'h11, 48'h12, 48'h13, 48'h10};
    for (int j = 0; j < 10; j++) begin
      wr_en    = (j < 4);
      wr_ad    = AW'(j);
      wr_data  = DW'(48'h10 + j);
      swap_req = (j == 1 || j == 2);
      if (j == 1) check("req_at_sweep1", {44'd0, sweep_ad}, 48'd1);
      step();
      check("swap_dout", dout, exp5[j]);
      check("swap_done_seq", {47'd0, swap_done}, (j == 3) ? 48'd1 : 48'd0);
      check("swap_bank_seq", {47'd0, active_bank}, (j >= 3) ? 48'd0 : 48'd1);
    end
    wr_en = 0; swap_req = 0;

    // 6: reset mid-sweep with a swap pending
    check("pre_rst_sweep", {44'd0, sweep_ad}, 48'd2);
    swap_req = 1;
    step();
    swap_req = 0;
    check("pend_no_fire", {47'd0, swap_done}, 48'd0);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    step();
    step();
    check_reset_vals("midrst_hold");
    reset = 1'b0;
    // Direct mode would fire a surviving pending swap on the very next edge.
    mode = 0; ad = 4'd0; ce = 1; oce = 1;
    step();
    check("post_rst_sdone1", {47'd0, swap_done}, 48'd0);
    check("post_rst_valid1", {47'd0, dout_valid}, 48'd0);
    check("post_rst_dout1", dout, 48'd0);
    step();
    check("post_rst_sdone2", {47'd0, swap_done}, 48'd0);
    check("post_rst_bank", {47'd0, active_bank}, 48'd0);
    check("mem_kept", dout, 48'h10);
    check("mem_kept_valid", {47'd0, dout_valid}, 48'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
